pointing_device_arbiter: RTL and testbench
==========================================

# pointing_device_arbiter

Shares the single CD-i input-port byte stream between two maneuvering-device sources, such as two emulated spoons or joystick-to-pointer converters. Each source is buffered in its own small FIFO. The block forwards whole device packets, never interleaving bytes of two packets. It rate-limits the output to one byte per serial frame time and forwards exactly one device-ID byte per RTS cycle. It sits between the device emulators and the UART slave model.

## Interface
Parameters:
- GAP, 250000: minimum cycles between output bytes (1200 baud at 30 MHz).
- GAP_OC, 200000: minimum gap when `overclock`=1.
- TIMEOUT, 600000: maximum mid-packet stall cycles before the packet is abandoned.
- DEPTH, 4: per-source FIFO depth (power of two).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rts  in  1  request-to-send from the CD-i side, active high
- overclock  in  1  selects GAP_OC instead of GAP
- rts_out  out  1  rts fanned out to both sources, combinational: rts | reset
- src0  sink  bytestream  source 0 bytes (data[7:0], write strobe)
- src1  sink  bytestream  source 1 bytes
- serial_out  source  bytestream  arbitrated output to the UART
- active  out  2  one-hot source currently granted; 0 when idle
- overflow  out  2  sticky per-source FIFO overflow flag

## Operation
- Byte classes: start byte has [7:6]=11; continuation byte has [7:6]=10.
- 0xCA is the ID packet, 1 byte long. Any other start byte opens a 3-byte packet.
- FIFO writes:
  - A write to a full FIFO drops the byte and sets that source's `overflow` bit.
  - Writes in a cycle where `rts` or `reset` is high are dropped.
- State IDLE, evaluated once per cycle:
  - Any FIFO head that is a continuation byte is popped and discarded. Both sources may be discarded in the same cycle.
  - A head of 0xCA while `id_seen`=1 is popped and discarded.
  - Among the remaining eligible start-byte heads, grant round-robin: the source not granted last wins a tie.
  - On grant: set `remaining` to 1 or 3, set `active`, go to SEND.
- State SEND, granted source s:
  - When the gap counter is 0 and s's FIFO is non-empty, the head is emitted and popped.
  - If `remaining`>1 and the head is a start byte, the packet is aborted: no pop, go to IDLE.
  - On emit: `remaining`--, gap counter = selected gap − 1. Emitting 0xCA sets `id_seen`.
  - When `remaining` reaches 0: `last` = s, go to IDLE.
- Stall: in SEND, a cycle with s's FIFO empty increments the stall counter.
  - The counter clears on each emit.
  - When it reaches TIMEOUT: go to IDLE, `last` = s, and do not emit the partial remainder.
- Gap counter: 20 bits, decrements to 0 and saturates there. It runs in every state.
- `rts`=1: every cycle, FIFOs are flushed, state = IDLE, `id_seen`=0, stall=0, gap=0, `active`=0.
  - `overflow` and `last` are preserved.
  - `rts` is level sensitive. After it falls, the first 0xCA from either source is forwarded.

## Timing
- Reset values:
  - `serial_out.write`=0, `serial_out.data`=0x00, `active`=0, `overflow`=0.
  - FIFOs empty, state IDLE, `id_seen`=0, `last`=src1 (so src0 wins the first tie), gap=0, stall=0.
- Byte written at cycle N is visible at the FIFO head at N+1. The earliest grant is at N+1, and the earliest emit is at N+2.
- `serial_out.write` is a registered single-cycle pulse, with `data` valid in the same cycle.
- Consecutive `serial_out.write` pulses are at least the selected gap apart. Changing `overclock` affects only the next reload.
- `serial_out.data` holds its last value between pulses.
- `active` updates the cycle after the grant decision and clears the cycle after the final emit, timeout or abort.
- The output never carries bytes of two packets interleaved. It never carries a continuation byte before a start byte from the same source.
- Simultaneous FIFO write and pop on the same FIFO are allowed; a full FIFO that is popped in the same cycle accepts the write.

## Test plan
All scenarios use GAP=10, GAP_OC=5, TIMEOUT=40.
- ID dedupe: pulse rts, then both sources write 0xCA in the same cycle -> exactly one 0xCA from src0; src1's 0xCA is discarded; a second rts pulse followed by src1 0xCA -> 0xCA forwarded.
- Packet atomicity and round-robin:
  - Stimulus: src0 writes C1,8A,85 and src1 writes C4,82,81, interleaved cycle by cycle.
  - Required: output C1,8A,85,C4,82,81 with writes ≥10 cycles apart and `active`=01 then 10.
- Pacing: with `overclock`=1, one 3-byte packet -> write pulses exactly 5 cycles apart once the bytes are buffered.
- Orphan and abort:
  - src0 writes 85 while idle -> dropped, no output.
  - src0 writes C0,81 then C2,83,84 -> output C0,81 (aborted), then C2,83,84.
- Timeout and overflow:
  - src1 writes C0,81 then stalls 40 cycles -> C0,81 emitted, `active` returns to 0, and a later 82 is discarded as an orphan.
  - 5 back-to-back writes to src0 with the output blocked by gap -> `overflow`=01.
- Reset mid-packet: assert reset after C3 has been emitted -> write=0 and `active`=0 next cycle; FIFO contents are lost and no further bytes are emitted.

Source files
------------

// File: rtl/pointing_device_arbiter.sv
// Arbitrates two pointing-device byte sources onto one paced serial stream.
// Whole packets only; one ID byte per RTS cycle; per-source FIFO buffering.
// Ports:
//   clk_i, reset_i (sync, active high), rts_i, overclock_i
//   rts_out_o               : rts_i | reset_i to both sources
//   srcN_data_i/_write_i    : source N byte strobe
//   serial_out_data_o/_write_o : paced output byte pulse
//   active_o (one-hot grant), overflow_o (sticky per-source)
module pointing_device_arbiter #(
  parameter int unsigned GAP     = 250000,
  parameter int unsigned GAP_OC  = 200000,
  parameter int unsigned TIMEOUT = 600000,
  parameter int unsigned DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rts_i,
  input  logic       overclock_i,
  output logic       rts_out_o,
  input  logic [7:0] src0_data_i,
  input  logic       src0_write_i,
  input  logic [7:0] src1_data_i,
  input  logic       src1_write_i,
  output logic [7:0] serial_out_data_o,
  output logic       serial_out_write_o,
  output logic [1:0] active_o,
  output logic [1:0] overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0]  ID_BYTE = 8'hCA;
  localparam logic [19:0] GAP_L   = 20'(GAP - 1);
  localparam logic [19:0] GAPOC_L = 20'(GAP_OC - 1);
  localparam logic [19:0] TO_L    = 20'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  function automatic logic is_start(input logic [7:0] b);
    return b[7:6] == 2'b11;
  endfunction

  logic [7:0]  wdata [2];
  logic [1:0]  wstb;
  logic [7:0]  mem_q [2][DEPTH];
  logic [AW:0] wr_q  [2];
  logic [AW:0] rd_q  [2];
  logic [7:0]  head  [2];
  logic [1:0]  empty, full, push, pop, ovf_set;

  state_e      state_q, state_d;
  logic        src_q, src_d;
  logic [1:0]  rem_q, rem_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [19:0] gap_q, gap_d;
  logic [19:0] stall_q, stall_d;
  logic [1:0]  active_q, active_d;
  logic        wr_q_o, wr_d_o;
  logic [7:0]  data_q, data_d;
  logic [1:0]  ovf_q;
  logic [1:0]  elig;
  logic        g;

  assign wdata[0] = src0_data_i;
  assign wdata[1] = src1_data_i;
  assign wstb     = {src1_write_i, src0_write_i};

  assign rts_out_o          = rts_i | reset_i;
  assign serial_out_data_o  = data_q;
  assign serial_out_write_o = wr_q_o;
  assign active_o           = active_q;
  assign overflow_o         = ovf_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = wr_q[i] == rd_q[i];
      full[i]  = (wr_q[i][AW] != rd_q[i][AW]) &&
                 (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
      head[i]  = mem_q[i][rd_q[i][AW-1:0]];
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i]    = wstb[i] && !rts_i && !reset_i && (!full[i] || pop[i]);
      ovf_set[i] = wstb[i] && !rts_i && !reset_i && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || rts_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + PW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_q[i][AW-1:0]] <= wdata[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rem_d    = rem_q;
    first_d  = first_q;
    last_d   = last_q;
    id_d     = id_q;
    gap_d    = (gap_q == '0) ? '0 : gap_q - 20'd1;
    stall_d  = stall_q;
    active_d = active_q;
    wr_d_o   = 1'b0;
    data_d   = data_q;
    pop      = '0;
    elig     = '0;
    g        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Non-start heads and repeat ID bytes can never open a packet.
        for (int i = 0; i < 2; i++) begin
          if (!empty[i]) begin
            if (is_start(head[i]) && !(head[i] == ID_BYTE && id_q))
              elig[i] = 1'b1;
            else
              pop[i] = 1'b1;
          end
        end
        if (elig == 2'b11) g = ~last_q;
        else               g = elig[1];
        if (elig != 2'b00) begin
          src_d    = g;
          rem_d    = (head[g] == ID_BYTE) ? 2'd1 : 2'd3;
          first_d  = 1'b1;
          stall_d  = '0;
          active_d = g ? 2'b10 : 2'b01;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (empty[src_q]) begin
          stall_d = stall_q + 20'd1;
          if (stall_d >= TO_L) begin
            stall_d  = '0;
            last_d   = src_q;
            active_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (!first_q && is_start(head[src_q])) begin
          // New packet arrived mid-packet: drop the rest, keep the head.
          stall_d  = '0;
          active_d = '0;
          state_d  = ST_IDLE;
        end else if (gap_q == '0) begin
          wr_d_o     = 1'b1;
          data_d     = head[src_q];
          pop[src_q] = 1'b1;
          rem_d      = rem_q - 2'd1;
          first_d    = 1'b0;
          stall_d    = '0;
          gap_d      = overclock_i ? GAPOC_L : GAP_L;
          if (head[src_q] == ID_BYTE) id_d = 1'b1;
          if (rem_q == 2'd1) begin
            last_d   = src_q;
            active_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rts_i) begin
      state_d  = ST_IDLE;
      id_d     = 1'b0;
      stall_d  = '0;
      gap_d    = '0;
      active_d = '0;
      wr_d_o   = 1'b0;
      pop      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      src_q    <= 1'b0;
      rem_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      gap_q    <= '0;
      stall_q  <= '0;
      active_q <= '0;
      wr_q_o   <= 1'b0;
      data_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      last_q   <= last_d;
      id_q     <= id_d;
      gap_q    <= gap_d;
      stall_q  <= stall_d;
      active_q <= active_d;
      wr_q_o   <= wr_d_o;
      data_q   <= data_d;
      ovf_q    <= ovf_q | ovf_set;
    end
  end

endmodule

// File: tb/tb_pointing_device_arbiter.sv
// Directed bench for pointing_device_arbiter.
// GAP=10, GAP_OC=5, TIMEOUT=40, DEPTH=4.
module tb_pointing_device_arbiter;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rts_i = 1'b0;
  logic       overclock_i = 1'b0;
  logic       rts_out_o;
  logic [7:0] src0_data_i = '0;
  logic       src0_write_i = 1'b0;
  logic [7:0] src1_data_i = '0;
  logic       src1_write_i = 1'b0;
  logic [7:0] serial_out_data_o;
  logic       serial_out_write_o;
  logic [1:0] active_o;
  logic [1:0] overflow_o;

  always #5 clk = ~clk;

  pointing_device_arbiter #(
    .GAP(10), .GAP_OC(5), .TIMEOUT(40), .DEPTH(4)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .rts_i(rts_i),
    .overclock_i(overclock_i),
    .rts_out_o(rts_out_o),
    .src0_data_i(src0_data_i),
    .src0_write_i(src0_write_i),
    .src1_data_i(src1_data_i),
    .src1_write_i(src1_write_i),
    .serial_out_data_o(serial_out_data_o),
    .serial_out_write_o(serial_out_write_o),
    .active_o(active_o),
    .overflow_o(overflow_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] obytes [$];
  int         ocyc   [$];
  logic [1:0] oact   [$];
  logic [7:0] exp_b  [$];
  logic [1:0] exp_a  [$];
  logic [1:0] prev_act = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (serial_out_write_o) begin
      obytes.push_back(serial_out_data_o);
      ocyc.push_back(cyc);
    end
    if (active_o != 2'b00 && active_o != prev_act)
      oact.push_back(active_o);
    prev_act = active_o;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1);
    src0_write_i = v0;
    src0_data_i  = d0;
    src1_write_i = v1;
    src1_data_i  = d1;
    tick();
    src0_write_i = 1'b0;
    src1_write_i = 1'b0;
  endtask

  task automatic clr();
    obytes.delete();
    ocyc.delete();
    oact.delete();
  endtask

  task automatic rts_pulse();
    rts_i = 1'b1;
    tick();
    check("rts_out_hi", 32'(rts_out_o), 32'd1);
    rts_i = 1'b0;
    tick();
  endtask

  task automatic check_out(input string tag);
    check({tag, "_n"}, 32'(obytes.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < obytes.size()) ? 32'(obytes[i]) : 32'hFFFF_FFFF,
            32'(exp_b[i]));
    check({tag, "_an"}, 32'(oact.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      check($sformatf("%s_a%0d", tag, i),
            (i < oact.size()) ? 32'(oact[i]) : 32'hFFFF_FFFF,
            32'(exp_a[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_wr", 32'(serial_out_write_o), 32'd0);
    check("rst_data", 32'(serial_out_data_o), 32'h00);
    check("rst_act", 32'(active_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_rtsout", 32'(rts_out_o), 32'd1);
    reset_i = 1'b0;
    tick();
    check("rtsout_lo", 32'(rts_out_o), 32'd0);

    // ID dedupe
    rts_pulse();
    clr();
    put(1'b1, 8'hCA, 1'b1, 8'hCA);
    idle(20);
    exp_b = '{8'hCA};
    exp_a = '{2'b01};
    check_out("id1");
    rts_pulse();
    clr();
    put(1'b0, 8'h00, 1'b1, 8'hCA);
    idle(20);
    exp_b = '{8'hCA};
    exp_a = '{2'b10};
    check_out("id2");

    // Atomicity and round-robin
    rts_pulse();
    clr();
    put(1'b1, 8'hC1, 1'b0, 8'h00);
    put(1'b0, 8'h00, 1'b1, 8'hC4);
    put(1'b1, 8'h8A, 1'b0, 8'h00);
    put(1'b0, 8'h00, 1'b1, 8'h82);
    put(1'b1, 8'h85, 1'b0, 8'h00);
    put(1'b0, 8'h00, 1'b1, 8'h81);
    idle(70);
    exp_b = '{8'hC1, 8'h8A, 8'h85, 8'hC4, 8'h82, 8'h81};
    exp_a = '{2'b01, 2'b10};
    check_out("rr");
    for (int i = 1; i < ocyc.size(); i++)
      check($sformatf("rr_gap%0d", i),
            32'((ocyc[i] - ocyc[i-1]) >= 10), 32'd1);

    // Overclock pacing
    overclock_i = 1'b1;
    rts_pulse();
    clr();
    put(1'b1, 8'hC5, 1'b0, 8'h00);
    put(1'b1, 8'h86, 1'b0, 8'h00);
    put(1'b1, 8'h87, 1'b0, 8'h00);
    idle(30);
    exp_b = '{8'hC5, 8'h86, 8'h87};
    exp_a = '{2'b01};
    check_out("oc");
    for (int i = 1; i < ocyc.size(); i++)
      check($sformatf("oc_gap%0d", i),
            32'(ocyc[i] - ocyc[i-1]), 32'd5);
    overclock_i = 1'b0;

    // Orphan then abort
    rts_pulse();
    clr();
    put(1'b1, 8'h85, 1'b0, 8'h00);
    idle(20);
    exp_b = {};
    exp_a = {};
    check_out("orph");
    clr();
    put(1'b1, 8'hC0, 1'b0, 8'h00);
    put(1'b1, 8'h81, 1'b0, 8'h00);
    put(1'b1, 8'hC2, 1'b0, 8'h00);
    put(1'b1, 8'h83, 1'b0, 8'h00);
    put(1'b1, 8'h84, 1'b0, 8'h00);
    idle(60);
    exp_b = '{8'hC0, 8'h81, 8'hC2, 8'h83, 8'h84};
    exp_a = '{2'b01, 2'b01};
    check_out("abort");
    check("abort_ovf", 32'(overflow_o), 32'd0);

    // Timeout
    rts_pulse();
    clr();
    put(1'b0, 8'h00, 1'b1, 8'hC0);
    put(1'b0, 8'h00, 1'b1, 8'h81);
    idle(28);
    check("to_wait_act", 32'(active_o), 32'h2);
    idle(40);
    check("to_act", 32'(active_o), 32'd0);
    exp_b = '{8'hC0, 8'h81};
    exp_a = '{2'b10};
    check_out("to");
    put(1'b0, 8'h00, 1'b1, 8'h82);
    idle(15);
    check("to_orph_n", 32'(obytes.size()), 32'd2);
    check("to_orph_act", 32'(active_o), 32'd0);

    // Overflow while gap blocks the output
    clr();
    put(1'b0, 8'h00, 1'b1, 8'hCA);
    tick();
    put(1'b1, 8'hC6, 1'b0, 8'h00);
    put(1'b1, 8'h88, 1'b0, 8'h00);
    put(1'b1, 8'h89, 1'b0, 8'h00);
    put(1'b1, 8'h8A, 1'b0, 8'h00);
    put(1'b1, 8'h8B, 1'b0, 8'h00);
    tick();
    check("ovf", 32'(overflow_o), 32'h1);
    idle(45);
    exp_b = '{8'hCA, 8'hC6, 8'h88, 8'h89};
    exp_a = '{2'b10, 2'b01};
    check_out("ovf");
    check("ovf_hold", 32'(serial_out_data_o), 32'h89);

    // Reset mid-packet
    rts_pulse();
    check("rts_keep_ovf", 32'(overflow_o), 32'h1);
    clr();
    put(1'b1, 8'hC3, 1'b0, 8'h00);
    put(1'b1, 8'h84, 1'b0, 8'h00);
    put(1'b1, 8'h85, 1'b0, 8'h00);
    for (int k = 0; k < 20 && obytes.size() == 0; k++) tick();
    check("mr_first", 32'(obytes.size()), 32'd1);
    reset_i = 1'b1;
    tick();
    check("mr_wr", 32'(serial_out_write_o), 32'd0);
    check("mr_act", 32'(active_o), 32'd0);
    check("mr_ovf", 32'(overflow_o), 32'd0);
    reset_i = 1'b0;
    idle(40);
    check("mr_n", 32'(obytes.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
